// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned BCD_DIGIT_W      = 4;
   localparam int unsigned ADJUST_THRESHOLD = 5;
   localparam int unsigned ADJUST_ADD       = 3;

   // Width of a counter that can hold 0..data_width.
   function automatic int unsigned step_cnt_w(input int unsigned data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adjusted_c
);

   // Pre-shift correction so the following doubling carries correctly.
   always_comb begin
      adjusted_c = digit;
      if (digit >= BCD_DIGIT_W'(ADJUST_THRESHOLD)) begin
         adjusted_c = digit + BCD_DIGIT_W'(ADJUST_ADD);
      end
   end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional leading-zero blanking mask enabled by BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_converter
   import bcd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_DIGITS = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_WIDTH-1:0]             i_data,
   input  logic                              i_2s_comp,
   input  logic                              i_valid,
   output logic                              o_ready,
   output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] o_bcd,
   output logic                              o_negative,
   output logic                              o_overflow,
   output logic [NUM_DIGITS-1:0]             o_blank,
   output logic                              o_valid,
   input  logic                              i_ready
);

   localparam int unsigned BCD_W = BCD_DIGIT_W * NUM_DIGITS;
   localparam int unsigned CNT_W = step_cnt_w(DATA_WIDTH);

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [DATA_WIDTH-1:0] mag, mag_n;
   logic [BCD_W-1:0]      bcd, bcd_n, bcd_adj_c;
   logic                  neg, neg_n;
   logic                  ovf, ovf_n;
   logic                  sign_c;

   assign sign_c = i_2s_comp & i_data[DATA_WIDTH-1];

   // One add-3 corrector per digit of the scratch register.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit      (bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .adjusted_c (bcd_adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mag   <= '0;
         bcd   <= '0;
         neg   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         mag   <= mag_n;
         bcd   <= bcd_n;
         neg   <= neg_n;
         ovf   <= ovf_n;
      end
   end

   // Next-state and datapath update: latch on accept, shift/adjust in SHIFT.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mag_n   = mag;
      bcd_n   = bcd;
      neg_n   = neg;
      ovf_n   = ovf;
      case (state)
         IDLE: begin
            if (i_valid) begin
               state_n = SHIFT;
               mag_n   = sign_c ? (~i_data + DATA_WIDTH'(1)) : i_data;
               neg_n   = sign_c;
               bcd_n   = '0;
               ovf_n   = 1'b0;
               cnt_n   = '0;
            end
         end
         SHIFT: begin
            {bcd_n, mag_n} = {bcd_adj_c[BCD_W-2:0], mag, 1'b0};
            ovf_n          = ovf | bcd_adj_c[BCD_W-1];
            cnt_n          = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
               state_n = DONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] blank, blank_c;
   logic                  upper_zero;

   // Leading-zero mask of the value about to enter DONE; the ones digit never blanks.
   always_comb begin
      blank_c    = '0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero & (bcd_n[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
         blank_c[k] = upper_zero;
      end
   end

   // Capture the mask on entry to DONE, clear it when a new word is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         blank <= '0;
      end else if (state == SHIFT && state_n == DONE) begin
         blank <= blank_c;
      end else if (state == IDLE && i_valid) begin
         blank <= '0;
      end
   end

   assign o_blank = blank;
`else
   assign o_blank = '0;
`endif

   assign o_ready    = (state == IDLE) & ~rst;
   assign o_valid    = (state == DONE);
   assign o_bcd      = bcd;
   assign o_negative = neg;
   assign o_overflow = ovf;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench for bin_to_bcd_converter, checked against a decimal-arithmetic model.
module tb_bin_to_bcd_converter;

   localparam int unsigned DW  = 16;
   localparam int unsigned ND  = 5;
   localparam int unsigned ND4 = 4;
   localparam int unsigned LAT = DW + 1;

   typedef struct {
      logic [4*ND-1:0] bcd;
      logic            neg;
      logic            ovf;
      logic [ND-1:0]   blank;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   i_data = '0;
   logic            i_2s_comp = 1'b0;
   logic            i_valid = 1'b0;
   logic            i_ready = 1'b1;
   logic            o_ready;
   logic [4*ND-1:0] o_bcd;
   logic            o_negative;
   logic            o_overflow;
   logic [ND-1:0]   o_blank;
   logic            o_valid;

   logic [DW-1:0]    d4_data = '0;
   logic             d4_valid = 1'b0;
   logic             d4_o_ready;
   logic [4*ND4-1:0] d4_bcd;
   logic             d4_neg;
   logic             d4_ovf;
   logic [ND4-1:0]   d4_blank;
   logic             d4_o_valid;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   hs_cyc   = 0;
   bit   first    = 1'b1;
   int   rdy_mode = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   bin_to_bcd_converter #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_2s_comp(i_2s_comp), .i_valid(i_valid),
      .o_ready(o_ready), .o_bcd(o_bcd), .o_negative(o_negative), .o_overflow(o_overflow),
      .o_blank(o_blank), .o_valid(o_valid), .i_ready(i_ready)
   );

   bin_to_bcd_converter #(.DATA_WIDTH(DW), .NUM_DIGITS(ND4)) dut4 (
      .clk(clk), .rst(rst), .i_data(d4_data), .i_2s_comp(1'b0), .i_valid(d4_valid),
      .o_ready(d4_o_ready), .o_bcd(d4_bcd), .o_negative(d4_neg), .o_overflow(d4_ovf),
      .o_blank(d4_blank), .o_valid(d4_o_valid), .i_ready(1'b1)
   );

   // Reference: magnitude in plain integers, digits by repeated division by ten.
   function automatic exp_t model(input logic [DW-1:0] d, input logic sc, input int nd);
      exp_t        e;
      int unsigned mag, v, p10;
      e.neg = sc && d[DW-1];
      mag   = e.neg ? (32'd65536 - 32'(d)) : 32'(d);
      p10   = 1;
      repeat (nd) p10 = p10 * 10;
      e.ovf = (mag >= p10);
      v     = mag % p10;
      e.bcd = '0;
      for (int k = 0; k < nd; k++) begin
         e.bcd[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      e.blank = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      begin
         bit all0;
         all0 = 1'b1;
         for (int k = nd - 1; k >= 1; k--) begin
            all0 = all0 && (e.bcd[4*k +: 4] == 4'd0);
            e.blank[k] = all0;
         end
      end
`endif
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      $display("FAIL %s: got no response, expected one within the cycle bound", nm);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready driver: always ready, random, or stalled.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       i_ready = 1'b1;
         1:       i_ready = ($urandom_range(3) != 0);
         default: i_ready = 1'b0;
      endcase
   end

   // Monitor: compare every presented result against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && i_valid && o_ready) hs_cyc = cyc;
      if (o_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got o_bcd 0x%0h, expected no result", o_bcd);
         end else begin
            if (first) begin
               check("latency", 32'(cyc - hs_cyc), 32'(LAT));
               first = 1'b0;
            end
            check("bcd",      32'(o_bcd),      32'(sb[0].bcd));
            check("negative", 32'(o_negative), 32'(sb[0].neg));
            check("overflow", 32'(o_overflow), 32'(sb[0].ovf));
            check("blank",    32'(o_blank),    32'(sb[0].blank));
            if (i_ready) begin
               sb.delete(0);
               first = 1'b1;
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic sc);
      int n = 0;
      while (!(o_ready && !rst)) begin
         step();
         n++;
         if (n > 200) begin
            timeout("send_ready");
            return;
         end
      end
      i_data    = d;
      i_2s_comp = sc;
      i_valid   = 1'b1;
      sb.push_back(model(d, sc, ND));
      step();
      i_valid   = 1'b0;
      i_data    = 16'($urandom);
      i_2s_comp = 1'($urandom);
   endtask

   task automatic drain;
      int n = 0;
      while (sb.size() != 0 || o_valid) begin
         step();
         n++;
         if (n > 3000) begin
            timeout("drain");
            return;
         end
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_ready"},    32'(o_ready),    32'd0);
      check({nm, "_valid"},    32'(o_valid),    32'd0);
      check({nm, "_bcd"},      32'(o_bcd),      32'd0);
      check({nm, "_negative"}, 32'(o_negative), 32'd0);
      check({nm, "_overflow"}, 32'(o_overflow), 32'd0);
      check({nm, "_blank"},    32'(o_blank),    32'd0);
   endtask

   task automatic send4(input logic [DW-1:0] d);
      exp_t e;
      int   n = 0;
      while (!d4_o_ready) begin
         step();
         n++;
         if (n > 200) begin
            timeout("send4_ready");
            return;
         end
      end
      d4_data  = d;
      d4_valid = 1'b1;
      step();
      d4_valid = 1'b0;
      d4_data  = 16'($urandom);
      n = 0;
      while (!d4_o_valid) begin
         step();
         n++;
         if (n > 100) begin
            timeout("send4_valid");
            return;
         end
      end
      e = model(d, 1'b0, ND4);
      check("d4_bcd",      32'(d4_bcd),   32'(e.bcd[4*ND4-1:0]));
      check("d4_overflow", 32'(d4_ovf),   32'(e.ovf));
      check("d4_negative", 32'(d4_neg),   32'(e.neg));
      check("d4_blank",    32'(d4_blank), 32'(e.blank[ND4-1:0]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Power-on reset: everything low while rst is high, ready right after.
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      #1;
      check("ready_after_reset", 32'(o_ready), 32'd1);

      // Directed corner values.
      send(16'h0000, 1'b0);
      drain();
      send(16'hFFFF, 1'b0);
      send(16'hFFFF, 1'b1);
      send(16'h8000, 1'b1);
      send(16'h7FFF, 1'b1);
      drain();

      // Backpressure: result held for 10 stalled cycles, then a one-cycle ready pulse.
      rdy_mode = 2;
      step();
      send(16'h3039, 1'b0);
      begin
         int n = 0;
         while (!o_valid && n < 100) begin
            step();
            n++;
         end
         if (!o_valid) timeout("stall_valid");
      end
      repeat (10) begin
         step();
         check("stall_valid", 32'(o_valid), 32'd1);
         check("stall_ready", 32'(o_ready), 32'd0);
         check("stall_bcd",   32'(o_bcd),   32'h12345);
      end
      rdy_mode = 0;
      step();
      rdy_mode = 2;
      step();
      check("release_valid", 32'(o_valid), 32'd0);
      check("release_ready", 32'(o_ready), 32'd1);
      rdy_mode = 0;
      drain();

      // Reset in the eighth SHIFT cycle aborts the conversion.
      send(16'h9234, 1'b1);
      repeat (7) step();
      rst = 1'b1;
      void'(sb.pop_back());
      step();
      check_all_zero("abort");
      rst = 1'b0;
      #1;
      check("ready_after_abort", 32'(o_ready), 32'd1);
      send(16'h0064, 1'b0);
      drain();

      // Randomised words with random downstream stalls.
      rdy_mode = 1;
      repeat (40) send(16'($urandom), 1'($urandom));
      drain();
      rdy_mode = 0;
      step();

      // Four-digit instance: overflow and full-range boundary.
      send4(16'd12345);
      send4(16'd9999);
      send4(16'd10000);
      send4(16'($urandom_range(0, 9999)));

      drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
